mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts mult/div/mt/mf operations and owns the HI/LO registers. It models the fixed multi-cycle latency of multiply and divide through a counter-driven FSM, and produces the `busy` and `start` signals that the hazard unit uses to stall md-class instructions in D.

---
 rtl/mdu_pkg.sv | 58 +++++
 rtl/mdu_divcore.sv | 49 ++++
 rtl/mdu_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit controller.
// Holds the md-class op encodings, FSM state and accumulate-mode enums,
// and small op-classification helpers.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU support).
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // How the pending product is merged into {hi,lo} when a MUL-path op commits.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } mdu_acc_e;

  // True for ops that launch a multi-cycle multiply or divide.
  // The accumulate variants only count as md ops when the feature is built in.
  function automatic logic is_muldiv(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the two divide ops (everything else md-class goes down the MUL path).
  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for multiply-family ops that treat their operands as signed.
  function automatic logic is_signed_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divcore.sv
// mdu_divcore: combinational 32-bit divider for the MDU.
// Signed mode truncates the quotient toward zero and gives the remainder the
// sign of the dividend. The 0x80000000 / -1 overflow case yields quotient
// 0x80000000, remainder 0. Division by zero raises divZero_o and forces
// both results to zero so no X ever escapes.
module mdu_divcore (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        divZero_o
);

  logic        negA;
  logic        negB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [31:0] safeB;
  logic [31:0] uQuot;
  logic [31:0] uRem;
  logic        overflow;

  // Reduce to an unsigned divide on magnitudes, then restore signs.
  always_comb begin
    negA        = signed_i & dividend_i[31];
    negB        = signed_i & divisor_i[31];
    magA        = negA ? (32'd0 - dividend_i) : dividend_i;
    magB        = negB ? (32'd0 - divisor_i) : divisor_i;
    safeB       = (magB == 32'd0) ? 32'd1 : magB;
    uQuot       = magA / safeB;
    uRem        = magA % safeB;
    divZero_o   = (divisor_i == 32'd0);
    overflow    = signed_i && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    quotient_o  = 32'd0;
    remainder_o = 32'd0;
    if (divZero_o) begin
      quotient_o  = 32'd0;
      remainder_o = 32'd0;
    end else if (overflow) begin
      quotient_o  = 32'h8000_0000;
      remainder_o = 32'd0;
    end else begin
      quotient_o  = (negA ^ negB) ? (32'd0 - uQuot) : uQuot;
      remainder_o = negA ? (32'd0 - uRem) : uRem;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the E stage.
// Owns HI/LO, computes the result at launch into pending registers and
// models the fixed multi-cycle latency with a down-counter, committing the
// pending result when the counter expires. busy/start feed the hazard unit.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {hi,lo} at commit.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        divZero_q, divZero_d;
`ifdef MDU_MADD_EN
  mdu_acc_e    accMode_q, accMode_d;
  mdu_acc_e    accSel;
  logic [63:0] accSum;
  logic [63:0] accDiff;
`endif

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [63:0] prodSel;
  logic [31:0] divQuot;
  logic [31:0] divRem;
  logic        divZero;

  mdu_divcore u_divcore (
    .dividend_i  (a),
    .divisor_i   (b),
    .signed_i    (op == OP_DIV),
    .quotient_o  (divQuot),
    .remainder_o (divRem),
    .divZero_o   (divZero)
  );

  assign prodU   = {32'd0, a} * {32'd0, b};
  assign prodS   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodSel = is_signed_mul(op) ? prodS : prodU;

  assign start = req && is_muldiv(op) && (state_q == ST_IDLE);
  assign busy  = (state_q != ST_IDLE);
  assign hi    = hi_q;
  assign lo    = lo_q;

`ifdef MDU_MADD_EN
  assign accSum  = {hi_q, lo_q} + {pendHi_q, pendLo_q};
  assign accDiff = {hi_q, lo_q} - {pendHi_q, pendLo_q};

  // Pick the accumulate mode for an op entering the MUL path.
  always_comb begin
    accSel = ACC_NONE;
    case (op)
      OP_MADD, OP_MADDU: accSel = ACC_ADD;
      OP_MSUB, OP_MSUBU: accSel = ACC_SUB;
      default:           accSel = ACC_NONE;
    endcase
  end
`endif

  // HI/LO read port for MFHI/MFLO, never blocked by the FSM.
  always_comb begin
    rdata = 32'd0;
    case (op)
      OP_MFHI: rdata = hi_q;
      OP_MFLO: rdata = lo_q;
      default: rdata = 32'd0;
    endcase
  end

  // Next-state logic: launch from IDLE, count down, commit on expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pendHi_d  = pendHi_q;
    pendLo_d  = pendLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divZero_d = divZero_q;
`ifdef MDU_MADD_EN
    accMode_d = accMode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_div(op)) begin
            pendLo_d  = divQuot;
            pendHi_d  = divRem;
            divZero_d = divZero;
            cnt_d     = DIV_LOAD;
            state_d   = ST_DIV;
          end else begin
            pendHi_d  = prodSel[63:32];
            pendLo_d  = prodSel[31:0];
            divZero_d = 1'b0;
            cnt_d     = MUL_LOAD;
            state_d   = ST_MUL;
`ifdef MDU_MADD_EN
            accMode_d = accSel;
`endif
          end
        end else if (req && (op == OP_MTHI)) begin
          hi_d = a;
        end else if (req && (op == OP_MTLO)) begin
          lo_d = a;
        end
      end
      ST_MUL: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
`ifdef MDU_MADD_EN
          case (accMode_q)
            ACC_ADD: {hi_d, lo_d} = accSum;
            ACC_SUB: {hi_d, lo_d} = accDiff;
            default: {hi_d, lo_d} = {pendHi_q, pendLo_q};
          endcase
`else
          hi_d = pendHi_q;
          lo_d = pendLo_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DIV: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (!divZero_q) begin
            hi_d = pendHi_q;
            lo_d = pendLo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pendHi_q  <= 32'd0;
      pendLo_q  <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      divZero_q <= 1'b0;
`ifdef MDU_MADD_EN
      accMode_q <= ACC_NONE;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pendHi_q  <= pendHi_d;
      pendLo_q  <= pendLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divZero_q <= divZero_d;
`ifdef MDU_MADD_EN
      accMode_q <= accMode_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (default parameters).
// Inputs change on the falling edge; outputs are observed on the falling edge
// or shortly after it.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int checks;
  int failures;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .op      (op),
    .a       (a),
    .b       (b),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rdata   (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present an md request on the falling edge; the next rising edge samples it.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    req = 1'b1;
    op  = o;
    a   = x;
    b   = y;
    #1;
  endtask

  // Let the launch edge pass, then count falling edges with busy high (bounded).
  task automatic runBusy(input logic keepReq, output int cycles);
    cycles = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0 && !keepReq) req = 1'b0;
      if (busy) cycles++;
      else break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = 1'b0; op = OP_MFHI; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL reset_start got=%b exp=0", start); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    int cyc;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL mult_start got=%b exp=1", start); end
    runBusy(1'b0, cyc);
    checks++; if (cyc != 5) begin failures++; $display("[TB] FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("[TB] FAIL mult_lo got=%h exp=fffffffa", lo); end
    op = OP_MFHI; #1;
    checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mfhi_rdata got=%h exp=ffffffff", rdata); end
    op = OP_MFLO; #1;
    checks++; if (rdata !== 32'hFFFF_FFFA) begin failures++; $display("[TB] FAIL mflo_rdata got=%h exp=fffffffa", rdata); end
    op = OP_MTHI; #1;
    checks++; if (rdata !== 32'd0) begin failures++; $display("[TB] FAIL rdata_other got=%h exp=0", rdata); end
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    runBusy(1'b0, cyc);
    checks++; if (cyc != 5) begin failures++; $display("[TB] FAIL multu_busy_cycles got=%0d exp=5", cyc); end
    checks++; if (hi !== 32'h0000_0002) begin failures++; $display("[TB] FAIL multu_hi got=%h exp=00000002", hi); end
    checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("[TB] FAIL multu_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_div;
    int cyc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    runBusy(1'b0, cyc);
    checks++; if (cyc != 10) begin failures++; $display("[TB] FAIL div_busy_cycles got=%0d exp=10", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    runBusy(1'b0, cyc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_negdivisor_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'h0000_0001) begin failures++; $display("[TB] FAIL div_negdivisor_hi got=%h exp=00000001", hi); end
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    runBusy(1'b0, cyc);
    checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL divu_lo got=%h exp=0", lo); end
    checks++; if (hi !== 32'h8000_0000) begin failures++; $display("[TB] FAIL divu_hi got=%h exp=80000000", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runBusy(1'b0, cyc);
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("[TB] FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_mt_divzero;
    int cyc;
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL mthi_start got=%b exp=0", start); end
    @(negedge clk);
    req = 1'b0; #1;
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("[TB] FAIL mthi_hi got=%h exp=12345678", hi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mthi_busy got=%b exp=0", busy); end
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    req = 1'b0; #1;
    checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL mtlo_lo got=%h exp=cafef00d", lo); end
    issue(OP_DIV, 32'd5, 32'd0);
    runBusy(1'b0, cyc);
    checks++; if (cyc != 10) begin failures++; $display("[TB] FAIL divzero_busy_cycles got=%0d exp=10", cyc); end
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("[TB] FAIL divzero_hi got=%h exp=12345678", hi); end
    checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL divzero_lo got=%h exp=cafef00d", lo); end
    issue(OP_DIVU, 32'd9, 32'd0);
    runBusy(1'b0, cyc);
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("[TB] FAIL divuzero_hi got=%h exp=12345678", hi); end
    checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL divuzero_lo got=%h exp=cafef00d", lo); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(OP_MULT, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    a = 32'd5; b = 32'd5; #1;
    checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL busy_start got=%b exp=0", start); end
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    checks++; if (cyc != 5) begin failures++; $display("[TB] FAIL b2b_first_cycles got=%0d exp=5", cyc); end
    checks++; if (lo !== 32'd12) begin failures++; $display("[TB] FAIL b2b_first_lo got=%h exp=0000000c", lo); end
    a = 32'd6; b = 32'd7; #1;
    checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart got=%b exp=1", start); end
    runBusy(1'b0, cyc);
    checks++; if (cyc != 5) begin failures++; $display("[TB] FAIL b2b_third_cycles got=%0d exp=5", cyc); end
    checks++; if (lo !== 32'd42) begin failures++; $display("[TB] FAIL b2b_third_lo got=%h exp=0000002a", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL b2b_third_hi got=%h exp=0", hi); end
  endtask

  task automatic test_reset_mid;
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    @(negedge clk);
    req = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL midreset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL midreset_lo got=%h exp=0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL postreset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL postreset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("[TB] FAIL postreset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_madd;
`ifdef MDU_MADD_EN
    int cyc;
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    checks++; if (start !== 1'b1) begin failures++; $display("[TB] FAIL madd_start got=%b exp=1", start); end
    runBusy(1'b0, cyc);
    checks++; if (cyc != 5) begin failures++; $display("[TB] FAIL madd_cycles got=%0d exp=5", cyc); end
    checks++; if (lo !== 32'd11) begin failures++; $display("[TB] FAIL madd_lo got=%h exp=0000000b", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("[TB] FAIL madd_hi got=%h exp=0", hi); end
    issue(OP_MSUBU, 32'd1, 32'd12);
    runBusy(1'b0, cyc);
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL msubu_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL msubu_lo got=%h exp=ffffffff", lo); end
`else
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    checks++; if (start !== 1'b0) begin failures++; $display("[TB] FAIL madd_off_start got=%b exp=0", start); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL madd_off_busy got=%b exp=0", busy); end
    req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (lo !== 32'd5) begin failures++; $display("[TB] FAIL madd_off_lo got=%h exp=00000005", lo); end
`endif
    req = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
